// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Clocked ALU with single-cycle ops, iterative shifts and
//            shift-add multiply, registered result/flags, start/busy/done.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [3:0]       i_alus,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_bus,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_zf,
    output logic             o_nf,
    output logic             o_cf,
    output logic             o_vf,
    output logic             o_err
);

    localparam int CNT_W = SHAMT_W + 1;
    localparam int MSB   = WIDTH - 1;

    localparam logic [3:0] c_OP_ZERO = 4'h0;
    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_SUB  = 4'h2;
    localparam logic [3:0] c_OP_INC  = 4'h3;
    localparam logic [3:0] c_OP_DEC  = 4'h4;
    localparam logic [3:0] c_OP_AND  = 4'h5;
    localparam logic [3:0] c_OP_OR   = 4'h6;
    localparam logic [3:0] c_OP_NOT  = 4'h7;
    localparam logic [3:0] c_OP_XOR  = 4'h8;
    localparam logic [3:0] c_OP_SHL  = 4'h9;
    localparam logic [3:0] c_OP_SHR  = 4'hA;
    localparam logic [3:0] c_OP_SAR  = 4'hB;
    localparam logic [3:0] c_OP_MUL  = 4'hC;
    localparam logic [3:0] c_OP_MULH = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_dout;
    logic                 r_done;
    logic                 r_zf;
    logic                 r_nf;
    logic                 r_cf;
    logic                 r_vf;
    logic                 r_err;

    logic                 w_fin;
    logic [WIDTH-1:0]     w_res;
    logic                 w_cf;
    logic                 w_vf;
    logic                 w_err;
    logic                 w_accept;
    logic                 w_is_shift;
    logic [SHAMT_W-1:0]   w_amt;
    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_sub;
    logic [WIDTH:0]       w_inc;
    logic [WIDTH:0]       w_dec;
    logic [WIDTH-1:0]     w_sh;
    logic                 w_sh_out;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_accept   = (r_state == ST_IDLE) && i_start;
    assign w_is_shift = (i_alus == c_OP_SHL) || (i_alus == c_OP_SHR) || (i_alus == c_OP_SAR);
    assign w_amt      = i_bus[SHAMT_W-1:0];
    assign w_add      = {1'b0, i_x} + {1'b0, i_bus};
    assign w_sub      = {1'b0, i_x} - {1'b0, i_bus};
    assign w_inc      = {1'b0, i_x} + (WIDTH+1)'(1);
    assign w_dec      = {1'b0, i_x} - (WIDTH+1)'(1);

    // Right-shifting shift-add: high half accumulates, low half holds the multiplier.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    always_comb begin
        w_sh     = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
        w_sh_out = r_a[0];
        if (r_op == c_OP_SHL) begin
            w_sh     = {r_a[WIDTH-2:0], 1'b0};
            w_sh_out = r_a[MSB];
        end else if (r_op == c_OP_SHR) begin
            w_sh     = {1'b0, r_a[WIDTH-1:1]};
            w_sh_out = r_a[0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fin        = 1'b0;
        w_res        = '0;
        w_cf         = 1'b0;
        w_vf         = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_fin = 1'b1;
                    case (i_alus)
                        c_OP_ZERO: w_res = '0;
                        c_OP_ADD: begin
                            w_res = w_add[MSB:0];
                            w_cf  = w_add[WIDTH];
                            w_vf  = (i_x[MSB] == i_bus[MSB]) && (w_add[MSB] != i_x[MSB]);
                        end
                        c_OP_SUB: begin
                            w_res = w_sub[MSB:0];
                            w_cf  = w_sub[WIDTH];
                            w_vf  = (i_x[MSB] != i_bus[MSB]) && (w_sub[MSB] != i_x[MSB]);
                        end
                        c_OP_INC: begin
                            w_res = w_inc[MSB:0];
                            w_cf  = w_inc[WIDTH];
                            w_vf  = !i_x[MSB] && w_inc[MSB];
                        end
                        c_OP_DEC: begin
                            w_res = w_dec[MSB:0];
                            w_cf  = w_dec[WIDTH];
                            w_vf  = i_x[MSB] && !w_dec[MSB];
                        end
                        c_OP_AND: w_res = i_x & i_bus;
                        c_OP_OR:  w_res = i_x | i_bus;
                        c_OP_NOT: w_res = ~i_x;
                        c_OP_XOR: w_res = i_x ^ i_bus;
                        c_OP_SHL, c_OP_SHR, c_OP_SAR: begin
                            w_res = i_x;
                            if (w_amt != '0) begin
                                w_fin        = 1'b0;
                                w_state_next = ST_SHIFT;
                            end
                        end
                        c_OP_MUL, c_OP_MULH: begin
                            w_fin        = 1'b0;
                            w_state_next = ST_MUL;
                        end
                        default: w_err = 1'b1;
                    endcase
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_fin        = 1'b1;
                    w_res        = w_sh;
                    w_cf         = w_sh_out;
                    w_state_next = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_fin        = 1'b1;
                    w_state_next = ST_IDLE;
                    if (r_op == c_OP_MULH) begin
                        w_res = w_acc_next[2*WIDTH-1:WIDTH];
                    end else begin
                        w_res = w_acc_next[WIDTH-1:0];
                        w_cf  = |w_acc_next[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_zf    <= 1'b0;
            r_nf    <= 1'b0;
            r_cf    <= 1'b0;
            r_vf    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_fin;
            if (w_fin) begin
                r_dout <= w_res;
                r_zf   <= (w_res == '0) && !w_err;
                r_nf   <= w_res[MSB];
                r_cf   <= w_cf;
                r_vf   <= w_vf;
                r_err  <= w_err;
            end
            if (w_accept) begin
                r_op  <= i_alus;
                r_a   <= i_x;
                r_acc <= {{WIDTH{1'b0}}, i_bus};
                r_cnt <= w_is_shift ? {1'b0, w_amt} : CNT_W'(WIDTH);
            end else if (r_state == ST_SHIFT) begin
                r_a   <= w_sh;
                r_cnt <= r_cnt - CNT_W'(1);
            end else if (r_state == ST_MUL) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_done = r_done;
    assign o_dout = r_dout;
    assign o_zf   = r_zf;
    assign o_nf   = r_nf;
    assign o_cf   = r_cf;
    assign o_vf   = r_vf;
    assign o_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq: directed table, corner-case
//            sequences and randomized ops against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    localparam int W  = 8;
    localparam int SW = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   alus;
    logic [W-1:0] x;
    logic [W-1:0] bus;
    logic         busy, done, zf, nf, cf, vf, err;
    logic [W-1:0] dout;

    alu_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_alus(alus), .i_x(x), .i_bus(bus),
        .o_busy(busy), .o_done(done), .o_dout(dout), .o_zf(zf), .o_nf(nf),
        .o_cf(cf), .o_vf(vf), .o_err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        logic [W-1:0] d;
        logic z, n, c, v, e;
        int lat;
    } res_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        res_t         exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, expv);
    endtask

    function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        int unsigned ua, ub, s;
        int sa, sb, ss, amt;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        amt = ub % W;
        r.d = '0; r.c = 0; r.v = 0; r.e = 0; r.lat = 0;
        case (op)
            4'h0: r.d = '0;
            4'h1, 4'h3: begin
                if (op == 4'h3) begin ub = 1; sb = 1; end
                s = ua + ub; ss = sa + sb;
                r.d = s[W-1:0]; r.c = s[W];
                r.v = (ss > 2**(W-1) - 1) || (ss < -(2**(W-1)));
            end
            4'h2, 4'h4: begin
                if (op == 4'h4) begin ub = 1; sb = 1; end
                s = ua - ub; ss = sa - sb;
                r.d = s[W-1:0]; r.c = (ua < ub);
                r.v = (ss > 2**(W-1) - 1) || (ss < -(2**(W-1)));
            end
            4'h5: r.d = a & b;
            4'h6: r.d = a | b;
            4'h7: r.d = ~a;
            4'h8: r.d = a ^ b;
            4'h9: begin
                s = ua << amt; r.d = s[W-1:0]; r.lat = amt;
                r.c = (amt != 0) ? s[W] : 1'b0;
            end
            4'hA, 4'hB: begin
                if (op == 4'hA) s = ua >> amt;
                else s = sa >>> amt;
                r.d = s[W-1:0]; r.lat = amt;
                r.c = (amt != 0) ? ((ua >> (amt - 1)) & 1) != 0 : 1'b0;
            end
            4'hC, 4'hD: begin
                s = ua * ub; r.lat = W;
                if (op == 4'hC) begin
                    r.d = s[W-1:0]; r.c = (s >> W) != 0;
                end else begin
                    r.d = s[2*W-1:W];
                end
            end
            default: r.e = 1;
        endcase
        r.z = (r.d == 0) && !r.e;
        r.n = r.d[W-1];
        return r;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output res_t got, output int busy_n, output logic [1:0] hs);
        int lat;
        lat = 0; busy_n = 0;
        @(negedge clk);
        start = 1'b1; alus = op; x = a; bus = b;
        @(posedge clk); #1;
        start = 1'b0; alus = 4'($urandom); x = W'($urandom); bus = W'($urandom);
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        got.d = dout; got.z = zf; got.n = nf; got.c = cf; got.v = vf; got.e = err;
        got.lat = lat;
        hs[1] = busy;
        @(posedge clk); #1;
        hs[0] = done;
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input res_t e);
        res_t g;
        int bn;
        logic [1:0] hs;
        run_op(op, a, b, g, bn, hs);
        check({tag, " dout"}, 32'(g.d), 32'(e.d));
        check({tag, " flags zncve"}, {27'd0, g.z, g.n, g.c, g.v, g.e}, {27'd0, e.z, e.n, e.c, e.v, e.e});
        check({tag, " latency"}, 32'(g.lat), 32'(e.lat));
        check({tag, " busy cycles"}, 32'(bn), 32'(e.lat));
        check({tag, " busy-at-done/done-after"}, {30'd0, hs}, 32'd0);
    endtask

    function automatic vec_t mkv(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] d, input logic [4:0] f, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b;
        v.exp.d = d; {v.exp.z, v.exp.n, v.exp.c, v.exp.v, v.exp.e} = f; v.exp.lat = lat;
        return v;
    endfunction

    initial begin
        vec_t tbl[18];
        int c0;
        logic [3:0] rop;
        logic [W-1:0] ra, rb;

        // flags packed as {zf, nf, cf, vf, err}
        tbl[0]  = mkv(4'h1, 8'hFF, 8'h01, 8'h00, 5'b10100, 0);
        tbl[1]  = mkv(4'h2, 8'h80, 8'h01, 8'h7F, 5'b00010, 0);
        tbl[2]  = mkv(4'h2, 8'h00, 8'h01, 8'hFF, 5'b01100, 0);
        tbl[3]  = mkv(4'hC, 8'h0F, 8'h11, 8'hFF, 5'b01000, 8);
        tbl[4]  = mkv(4'hD, 8'h80, 8'h04, 8'h02, 5'b00000, 8);
        tbl[5]  = mkv(4'hB, 8'h90, 8'h03, 8'hF2, 5'b01000, 3);
        tbl[6]  = mkv(4'h9, 8'h81, 8'h01, 8'h02, 5'b00100, 1);
        tbl[7]  = mkv(4'hA, 8'hA5, 8'h08, 8'hA5, 5'b01000, 0);
        tbl[8]  = mkv(4'h3, 8'h7F, 8'h00, 8'h80, 5'b01010, 0);
        tbl[9]  = mkv(4'h4, 8'h00, 8'h00, 8'hFF, 5'b01100, 0);
        tbl[10] = mkv(4'h5, 8'hF0, 8'h3C, 8'h30, 5'b00000, 0);
        tbl[11] = mkv(4'h6, 8'hF0, 8'h3C, 8'hFC, 5'b01000, 0);
        tbl[12] = mkv(4'h7, 8'h0F, 8'h00, 8'hF0, 5'b01000, 0);
        tbl[13] = mkv(4'h8, 8'hFF, 8'hFF, 8'h00, 5'b10000, 0);
        tbl[14] = mkv(4'h0, 8'h12, 8'h34, 8'h00, 5'b10000, 0);
        tbl[15] = mkv(4'hF, 8'h12, 8'h34, 8'h00, 5'b00001, 0);
        tbl[16] = mkv(4'h1, 8'h01, 8'h01, 8'h02, 5'b00000, 0);
        tbl[17] = mkv(4'hA, 8'h81, 8'h07, 8'h01, 5'b00000, 7);

        rst = 1'b1; start = 1'b0; alus = 4'h0; x = '0; bus = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset dout", 32'(dout), 32'd0);
        check("reset status", {25'd0, busy, done, zf, nf, cf, vf, err}, 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 18; i++)
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

        // ADD requests while a MUL is running must be ignored
        c0 = done_cnt;
        @(negedge clk); start = 1'b1; alus = 4'hC; x = 8'h0F; bus = 8'h11;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); start = 1'b1; alus = 4'h1; x = 8'h01; bus = 8'h01;
        end
        @(negedge clk); start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("ignore done at E0+8", 32'(done), 32'd1);
        check("ignore dout", 32'(dout), 32'hFF);
        repeat (4) @(posedge clk);
        #1;
        check("ignore done count", 32'(done_cnt - c0), 32'd1);
        check("ignore dout held", 32'(dout), 32'hFF);

        // reset in the middle of a MUL aborts it
        @(negedge clk); start = 1'b1; alus = 4'hC; x = 8'hFF; bus = 8'hFF;
        @(posedge clk); #1; start = 1'b0;
        c0 = done_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("midrst dout", 32'(dout), 32'd0);
        check("midrst status", {25'd0, busy, done, zf, nf, cf, vf, err}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midrst no done", 32'(done_cnt - c0), 32'd0);
        check("midrst idle", 32'(busy), 32'd0);

        for (int i = 0; i < 250; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = W'($urandom);
            rb  = W'($urandom);
            if (i % 8 == 0) rb = W'($urandom_range(0, 1) * (2**W - 1));
            do_op($sformatf("rnd%0d op%0h %0h,%0h", i, rop, ra, rb), rop, ra, rb, model(rop, ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
